// File: rtl/mem_pkg.sv
// Shared memory-side types: responder FSM states and line/word geometry helper.
// Also imported by the cache fill logic.
package mem_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic int words_per_line(input int line_width);
        return line_width / WORD_WIDTH;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised main-memory storage with one line-wide write port and one
// line-wide combinational read port; contents are never reset.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int LINE_WIDTH  = 128,
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [LINE_WIDTH-1:0] wr_line,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [LINE_WIDTH-1:0] rd_line
);

    localparam int WPL = words_per_line(LINE_WIDTH);

    logic [WORD_WIDTH-1:0] data [DEPTH_WORDS];

    // Indices are line aligned, so base + word offset never crosses a line.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WPL; i++) begin
                data[wr_idx + IDX_W'(i)] <= wr_line[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    always_comb begin
        rd_line = '0;
        for (int i = 0; i < WPL; i++) begin
            rd_line[i*WORD_WIDTH +: WORD_WIDTH] = data[rd_idx + IDX_W'(i)];
        end
    end

endmodule

// File: rtl/mem_line_responder.sv
// Single-outstanding cache-line memory responder: accepts one line read/write,
// answers after LATENCY cycles and holds the response until it is taken.
module mem_line_responder
    import mem_pkg::*;
#(
    parameter int LINE_WIDTH  = 128,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LINE_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LINE_WIDTH-1:0] resp_rdata,
    output logic                  resp_write
);

    localparam int WPL   = words_per_line(LINE_WIDTH);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IDX_W-1:0] LINE_MASK = ~IDX_W'(WPL - 1);

    mem_state_t            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  resp_write_q, resp_write_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [LINE_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

    logic [IDX_W-1:0]      req_idx;
    logic [IDX_W-1:0]      rd_idx;
    logic [LINE_WIDTH-1:0] rd_line;
    logic                  accept;
    logic                  wr_en;
    logic                  enter_resp;
    logic                  line_is_write;
    logic                  unused_addr;

    // Word index modulo the array depth, with the line-offset words cleared.
    assign req_idx     = req_addr[IDX_W+1:2] & LINE_MASK;
    assign accept      = (state_q == IDLE) && req_valid;
    assign wr_en       = accept && req_write;
    assign rd_idx      = (state_q == IDLE) ? req_idx : idx_q;
    assign unused_addr = ^req_addr;

    mem_word_array #(
        .LINE_WIDTH  (LINE_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (req_idx),
        .wr_line (req_wdata),
        .rd_idx  (rd_idx),
        .rd_line (rd_line)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        resp_write_d  = resp_write_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_rdata_d  = resp_rdata_q;
        enter_resp    = 1'b0;
        line_is_write = resp_write_q;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    idx_d         = req_idx;
                    resp_write_d  = req_write;
                    line_is_write = req_write;
                    cnt_d         = CNT_W'(LATENCY - 1);
                    req_ready_d   = 1'b0;
                    if (LATENCY == 1) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // Leaving on the edge that takes the counter to zero keeps
                // the response exactly LATENCY cycles after acceptance.
                if (cnt_q == CNT_W'(1)) begin
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase

        if (enter_resp) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = line_is_write ? '0 : rd_line;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            resp_write_q <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_write_q <= resp_write_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        idx_q <= idx_d;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_write = resp_write_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench for mem_line_responder: a word-array model predicts every
// response at acceptance; a negedge monitor pops and compares on handshake.
module tb_mem_line_responder;
    import mem_pkg::*;

    localparam int LW    = 128;
    localparam int AW    = 32;
    localparam int DEPTH = 4096;
    localparam int LAT   = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          resp_ready = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [LW-1:0] req_wdata = '0;
    logic          req_ready;
    logic          resp_valid;
    logic          resp_write;
    logic [LW-1:0] resp_rdata;

    typedef struct packed {
        logic          wr;
        logic [LW-1:0] rdata;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem_m [DEPTH];
    bit          wrote [DEPTH/4];
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    mem_line_responder #(
        .LINE_WIDTH  (LW),
        .ADDR_WIDTH  (AW),
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_write (resp_write)
    );

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'(((addr >> 2) & 32'hFFFF_FFFC) % DEPTH);
    endfunction

    function automatic logic [LW-1:0] line_of(input int idx);
        logic [LW-1:0] l;
        for (int w = 0; w < 4; w++) l[w*32 +: 32] = mem_m[idx + w];
        return l;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && resp_valid && resp_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_resp", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_write", resp_write, e.wr);
            end
        end
    end

    task automatic txn(input bit wr, input logic [31:0] addr, input logic [LW-1:0] wd,
                       input int stall, input bit compete, input logic [31:0] c_addr);
        int            idx;
        int            n;
        logic [LW-1:0] want;
        logic [LW-1:0] held;
        exp_t          e;
        idx = idx_of(addr);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_write  = wr;
        req_addr   = addr;
        req_wdata  = wd;
        resp_ready = (stall == 0);
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (wr) begin
            for (int w = 0; w < 4; w++) mem_m[idx + w] = wd[w*32 +: 32];
            wrote[idx/4] = 1'b1;
            want = '0;
        end else begin
            want = line_of(idx);
        end
        e.wr = wr;
        e.rdata = want;
        sb_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, LAT);
        if (!resp_valid) return;
        if (stall > 0) begin
            held = resp_rdata;
            if (compete) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = c_addr;
                req_wdata = ~wd;
            end
            for (int s = 0; s < stall; s++) begin
                @(posedge clk); #1;
                chk("stall_rdata", resp_rdata, held);
                chk("stall_valid", resp_valid, 1);
                chk("stall_req_ready", req_ready, 0);
            end
            req_valid  = 1'b0;
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("req_ready_after_hs", req_ready, 1);
        chk("resp_valid_after_hs", resp_valid, 0);
        resp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;

        #1 rst = 1'b1;
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_write", resp_write, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        txn(1'b1, 32'h2000, {32'h00308193, 32'h00200113, 32'h00100093, 32'h00000013}, 0, 1'b0, 0);
        chk("preload_data2048", dut.u_array.data[2048], 32'h13);
        txn(1'b0, 32'h2000, '0, 0, 1'b0, 0);

        txn(1'b1, 32'h40, 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0, 0, 1'b0, 0);
        txn(1'b0, 32'h4C, '0, 0, 1'b0, 0);

        txn(1'b1, 32'h10, 128'h11111111_22222222_33333333_44444444, 0, 1'b0, 0);
        txn(1'b0, DEPTH*4 + 32'h10, '0, 0, 1'b0, 0);
        txn(1'b1, DEPTH*4 + 32'h30, 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0, 0, 1'b0, 0);
        txn(1'b0, 32'h30, '0, 0, 1'b0, 0);

        txn(1'b1, 32'h80, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 0, 1'b0, 0);
        txn(1'b0, 32'h40, '0, 20, 1'b1, 32'h80);
        txn(1'b0, 32'h80, '0, 0, 1'b0, 0);

        for (int k = 0; k < 12; k++) begin
            int          l;
            logic [31:0] a;
            l = $urandom_range(0, 15);
            a = 32'(l * 16) + 32'($urandom_range(0, 15));
            if (!wrote[idx_of(a)/4] || $urandom_range(0, 1) == 1)
                txn(1'b1, a, {$urandom(), $urandom(), $urandom(), $urandom()}, 0, 1'b0, 0);
            else
                txn(1'b0, a, '0, $urandom_range(0, 3), 1'b0, 0);
        end

        txn(1'b0, 32'h2000, '0, 0, 1'b0, 0);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h40;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, 1);
        chk("midrst_resp_valid", resp_valid, 0);
        chk("midrst_resp_rdata", resp_rdata, 0);
        chk("midrst_resp_write", resp_write, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        chk("no_resp_after_rst", seen, 0);
        chk("data2048_after_rst", dut.u_array.data[2048], 32'h13);
        resp_ready = 1'b0;
        txn(1'b0, 32'h2000, '0, 0, 1'b0, 0);
        txn(1'b0, 32'h4C, '0, 0, 1'b0, 0);

        repeat (3) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Main-memory responder for the SoC: accepts one cache-line read or write request at a time from the cache/fill logic and answers after a fixed, programmable latency. It sits at the memory end of the cache-to-memory interface. It owns the word array `data` that testbenches preload with `$readmemh` at a word offset, e.g. program image at word 2048.

## Interface
- `LINE_WIDTH`, 128: bits per cache line; a multiple of 32.
- `ADDR_WIDTH`, 32: byte-address width.
- `DEPTH_WORDS`, 4096: number of 32-bit words in `data`; a power of two.
- `LATENCY`, 5: cycles from request acceptance to `resp_valid`; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_write`  in  1  1 = line write, 0 = line read.
- `req_addr`  in  ADDR_WIDTH  byte address; the low `$clog2(LINE_WIDTH/8)` bits are ignored.
- `req_wdata`  in  LINE_WIDTH  write line; word 0 is in bits [31:0].
- `resp_valid`  out  1  response present; for writes it is a write acknowledge.
- `resp_ready`  in  1  requester accepts the response.
- `resp_rdata`  out  LINE_WIDTH  read line; 0 for write acknowledges.
- `resp_write`  out  1  echoes `req_write` of the transaction being answered.

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`, capture `req_write`, the line-aligned word index and `req_wdata`.
  - Load the counter with `LATENCY-1`.
  - Go to WAIT, or go directly to RESP when `LATENCY`==1.
- **WAIT:**
  - `req_ready`=0.
  - Decrement the counter each cycle; at 0, go to RESP.
- **RESP:**
  - `resp_valid`=1 and the response fields are stable.
  - On `resp_ready`, return to IDLE.
  - There is no same-cycle re-accept: `req_ready` rises in the cycle after the response handshake.
- **Writes:**
  - All `LINE_WIDTH/32` words are written to `data` at the acceptance edge.
  - Consecutive words start at the line base index.
- **Reads:**
  - `resp_rdata` is assembled from `data` at the edge that enters RESP.
  - It is registered and held until the handshake.
- **Addressing:**
  - Word index = `req_addr[ADDR_WIDTH-1:2]` with the line-offset bits cleared.
  - Taken modulo `DEPTH_WORDS`, so addresses beyond the array wrap to word 0.
- **One outstanding transaction only.** A `req_valid` seen while not in IDLE is ignored and not queued; the requester holds it.
- **Reset:**
  - Forces IDLE, clears the counter, `resp_valid`, `resp_rdata` and `resp_write`.
  - Any in-flight transaction is dropped with no response. A write already accepted stays committed.
  - The `data` contents are never cleared by reset, so the preloaded image survives.

## Timing
- **Reset values:** `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_write`=0.
- **Latency:**
  - A request accepted at edge T produces `resp_valid`=1 in the cycle after edge T+`LATENCY`−1.
  - That is, exactly `LATENCY` cycles after acceptance.
- **Stall:** with `resp_ready` low, RESP is held indefinitely with unchanged outputs.
- **Throughput:** one transaction per `LATENCY`+1 cycles when `resp_ready` is tied high.
- **Async reset:** asserting `rst` in any state drives outputs to their reset values immediately, without waiting for a clock edge.

## Structure
- **Shared package `mem_pkg`:**
  - State enum `mem_state_t` {IDLE, WAIT, RESP}.
  - `WORD_WIDTH`=32.
  - The `WORDS_PER_LINE` helper.
  - Reused by the cache fill logic.
- **Sub-module `mem_word_array`:**
  - Holds the word array `data`, hierarchically reachable as `<inst>.data` for `$readmemh`.
  - One line-wide write port and one line-wide combinational read port.
- **`mem_line_responder`** keeps the FSM, counter and capture registers.

## Test plan
- **Reset:** assert `rst` mid-simulation → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0 with no clock edge; preloaded `data[2048]` unchanged.
- **Preloaded read:**
  - Stimulus: preload `data[2048..2051]` = 0x00000013, 0x00100093, 0x00200113, 0x00308193; read `req_addr`=0x2000 accepted at cycle 10.
  - Required: `resp_valid` in cycle 15, `resp_rdata`=0x00308193_00200113_00100093_00000013, `resp_write`=0.
- **Write then read:**
  - Stimulus: write `req_addr`=0x40 with 0xDEADBEEF_CAFEF00D_12345678_9ABCDEF0 → acknowledge after 5 cycles with `resp_rdata`=0.
  - Required: a subsequent read of 0x4C (unaligned) returns the same line.
- **Response stall:** hold `resp_ready`=0 for 20 cycles after `resp_valid` → outputs stable; `req_ready`=0; a competing `req_valid` is ignored until 1 cycle after the handshake.
- **Reset mid-WAIT:** pulse `rst` 2 cycles after a read is accepted → no `resp_valid` ever appears for it; `req_ready`=1 immediately.
- **Wrap:** read `req_addr`=`DEPTH_WORDS`*4 + 0x10 → data returned from words 4..7.
